// File: rtl/mac_rr_scheduler_pkg.sv
// Shared definitions for the MAC round-robin scheduler.
//   - State encoding of the scheduler FSM (IDLE=0, STREAM=1, WAIT_RES=2, RESP=3).
//   - clog2(): width helper for requester indices and counters (never below 1).
package mac_rr_scheduler_pkg;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_STREAM   = 2'd1;
    localparam logic [1:0] ENC_WAIT_RES = 2'd2;
    localparam logic [1:0] ENC_RESP     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_STREAM   = ENC_STREAM,
        ST_WAIT_RES = ENC_WAIT_RES,
        ST_RESP     = ENC_RESP
    } state_t;

    // Ceiling log2, clamped to 1 so a 1-bit index exists even for tiny counts.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the highest-priority requester this round
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_idx   : index of the granted requester (0 when nothing requests)
module mac_rr_scheduler_rr_arbiter
    import mac_rr_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic w_found;

    // Walk the requesters starting at i_ptr and wrapping; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            logic [IW-1:0] jj;
            j = int'(i_ptr) + i;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (!w_found && i_req[jj]) begin
                o_grant[jj] = 1'b1;
                o_idx       = jj;
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Packet-granular round-robin scheduler in front of a single shared MAC.
// Ports:
//   clock, rstn                   : clock (rising edge), async active-low reset
//   req_valid/last/a/b, req_ready : per-requester beat streams (slice i = requester i)
//   mac_valid/last/a/b, mac_ready : beat stream to the MAC (combinational from owner)
//   mac_res_valid/res/ovf         : MAC result pulse, only honoured in WAIT_RES
//   res_valid/ready/data/id/len/err : registered result returned to the owner
//   busy                          : scheduler not idle
//   dbg_state                     : current FSM state encoding
// Handshake: a transfer happens on any cycle where valid && ready are both high;
// valid never depends on ready, and the result payload holds until accepted.
module mac_rr_scheduler
    import mac_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 14,
    parameter int B_W     = 14,
    parameter int RES_W   = 28,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clock,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*A_W-1:0]      req_a,
    input  logic [NUM_REQ*B_W-1:0]      req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        mac_valid,
    output logic                        mac_last,
    output logic [A_W-1:0]              mac_a,
    output logic [B_W-1:0]              mac_b,
    input  logic                        mac_ready,
    input  logic                        mac_res_valid,
    input  logic [RES_W-1:0]            mac_res,
    input  logic                        mac_ovf,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [RES_W-1:0]            res_data,
    output logic [clog2(NUM_REQ)-1:0]   res_id,
    output logic [LEN_W-1:0]            res_len,
    output logic                        res_err,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int ID_W = clog2(NUM_REQ);
    localparam int TO_W = clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [RES_W-1:0]   r_res_data;
    logic               r_res_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic               w_stream;
    logic               w_own_valid;
    logic               w_own_last;
    logic               w_beat_acc;

    mac_rr_scheduler_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any       = |w_grant;
    assign w_stream    = (r_state == ST_STREAM);
    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];

    // Beat path is a plain mux on the locked owner; zero outside STREAM.
    assign mac_valid  = w_stream & w_own_valid;
    assign mac_last   = w_stream & w_own_last;
    assign mac_a      = w_stream ? req_a[int'(r_owner)*A_W +: A_W] : '0;
    assign mac_b      = w_stream ? req_b[int'(r_owner)*B_W +: B_W] : '0;
    assign w_beat_acc = mac_valid & mac_ready;

    always_comb begin
        req_ready = '0;
        if (w_stream) req_ready[r_owner] = mac_ready;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_idx;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_beat_acc) begin
                        if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        if (w_own_last) begin
                            r_to_cnt <= '0;
                            r_state  <= ST_WAIT_RES;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    // A result on the final timeout cycle still wins.
                    if (mac_res_valid) begin
                        r_res_data <= mac_res;
                        r_res_err  <= mac_ovf;
                        r_state    <= ST_RESP;
                    end else if (r_to_cnt == TO_MAX) begin
                        r_res_data <= '0;
                        r_res_err  <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        // The requester just served drops to lowest priority.
                        r_ptr      <= (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
                        r_beat_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = (r_state == ST_RESP);
    assign res_data  = r_res_data;
    assign res_id    = r_owner;
    assign res_len   = r_beat_cnt;
    assign res_err   = r_res_err;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
module tb_mac_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int A_W     = 14;
    localparam int B_W     = 14;
    localparam int RES_W   = 28;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    // ---------------- clock / reset ----------------
    logic clock;
    logic rstn;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   mac_valid;
    logic                   mac_last;
    logic [A_W-1:0]         mac_a;
    logic [B_W-1:0]         mac_b;
    logic                   mac_ready;
    logic                   mac_res_valid;
    logic [RES_W-1:0]       mac_res;
    logic                   mac_ovf;
    logic                   res_valid;
    logic                   res_ready;
    logic [RES_W-1:0]       res_data;
    logic [ID_W-1:0]        res_id;
    logic [LEN_W-1:0]       res_len;
    logic                   res_err;
    logic                   busy;
    logic [1:0]             dbg_state;

    mac_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .A_W     (A_W),
        .B_W     (B_W),
        .RES_W   (RES_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .mac_valid     (mac_valid),
        .mac_last      (mac_last),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_ready     (mac_ready),
        .mac_res_valid (mac_res_valid),
        .mac_res       (mac_res),
        .mac_ovf       (mac_ovf),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_id        (res_id),
        .res_len       (res_len),
        .res_err       (res_err),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int exp_owner [5] = '{0, 1, 2, 3, 0};

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        req_valid[i]        = v;
        req_last[i]         = l;
        req_a[i*A_W +: A_W] = a;
        req_b[i*B_W +: B_W] = b;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_state"},     64'(dbg_state), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_mac_valid"}, 64'(mac_valid), 64'd0);
        check({tag, "_mac_last"},  64'(mac_last),  64'd0);
        check({tag, "_mac_a"},     64'(mac_a),     64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_data"},  64'(res_data),  64'd0);
        check({tag, "_res_id"},    64'(res_id),    64'd0);
        check({tag, "_res_len"},   64'(res_len),   64'd0);
        check({tag, "_res_err"},   64'(res_err),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        req_a         = '0;
        req_b         = '0;
        mac_ready     = 1'b0;
        mac_res_valid = 1'b0;
        mac_res       = '0;
        mac_ovf       = 1'b0;
        res_ready     = 1'b0;

        // ---- reset state ----
        #12;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // ---- single requester 1, 3-beat packet ----
        set_req(1, 1'b1, 1'b0, 14'h0011, 14'h0022);
        mac_ready = 1'b1;
        #1;
        check("t1_idle_no_accept", 64'(req_ready), 64'd0);
        step();
        check("t1_state_stream", 64'(dbg_state), 64'd1);
        check("t1_ready_b1", 64'(req_ready), 64'b0010);
        check("t1_mac_valid", 64'(mac_valid), 64'd1);
        check("t1_mac_a_b1", 64'(mac_a), 64'h11);
        check("t1_mac_b_b1", 64'(mac_b), 64'h22);
        step();
        check("t1_len_after_b1", 64'(res_len), 64'd1);
        set_req(1, 1'b1, 1'b0, 14'h0033, 14'h0044);
        #1;
        check("t1_ready_b2", 64'(req_ready), 64'b0010);
        check("t1_mac_a_b2", 64'(mac_a), 64'h33);
        step();
        set_req(1, 1'b1, 1'b1, 14'h0055, 14'h0066);
        #1;
        check("t1_ready_b3", 64'(req_ready), 64'b0010);
        check("t1_mac_last", 64'(mac_last), 64'd1);
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 14'h0);
        #1;
        check("t1_state_wait", 64'(dbg_state), 64'd2);
        check("t1_wait_mac_valid", 64'(mac_valid), 64'd0);
        step();
        mac_res_valid = 1'b1;
        mac_res       = 28'h0000640;
        step();
        mac_res_valid = 1'b0;
        mac_res       = '0;
        #1;
        check("t1_res_valid", 64'(res_valid), 64'd1);
        check("t1_res_id", 64'(res_id), 64'd1);
        check("t1_res_len", 64'(res_len), 64'd3);
        check("t1_res_data", 64'(res_data), 64'h640);
        check("t1_res_err", 64'(res_err), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        #1;
        check("t1_back_idle", 64'(busy), 64'd0);

        // ---- reset pulse so round robin starts from requester 0 ----
        rstn = 1'b0;
        #1;
        check_reset_outputs("pulse");
        rstn = 1'b1;

        // ---- all requesters valid, 2-beat packets, fairness ----
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 14'(16*i + 1), 14'(16*i + 2));
        res_ready = 1'b1;
        mac_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t2_idle_%0d", k), 64'(dbg_state), 64'd0);
            step();
            check($sformatf("t2_grant_%0d", k), 64'(req_ready), 64'(1 << exp_owner[k]));
            check($sformatf("t2_mac_a_%0d", k), 64'(mac_a), 64'(16*exp_owner[k] + 1));
            step();
            req_last = '1;
            #1;
            check($sformatf("t2_grant_b2_%0d", k), 64'(req_ready), 64'(1 << exp_owner[k]));
            step();
            req_last      = '0;
            mac_res_valid = 1'b1;
            mac_res       = 28'(exp_owner[k]*256 + 7);
            step();
            mac_res_valid = 1'b0;
            #1;
            check($sformatf("t2_res_id_%0d", k), 64'(res_id), 64'(exp_owner[k]));
            check($sformatf("t2_res_len_%0d", k), 64'(res_len), 64'd2);
            check($sformatf("t2_res_data_%0d", k), 64'(res_data), 64'(exp_owner[k]*256 + 7));
            step();
        end
        res_ready = 1'b0;
        req_valid = '0;
        req_last  = '0;

        // ---- requester 2 locked while requester 0 waits ----
        set_req(2, 1'b1, 1'b0, 14'h0021, 14'h0022);
        #1;
        step();
        check("t3_owner2", 64'(req_ready), 64'b0100);
        step();
        set_req(0, 1'b1, 1'b0, 14'h0001, 14'h0002);
        #1;
        check("t3_locked_stream", 64'(req_ready), 64'b0100);
        check("t3_mac_a_owner2", 64'(mac_a), 64'h21);
        req_last[2] = 1'b1;
        step();
        set_req(2, 1'b0, 1'b0, 14'h0, 14'h0);
        #1;
        check("t3_wait_no_ready", 64'(req_ready), 64'd0);
        mac_res_valid = 1'b1;
        mac_res       = 28'h0000ABC;
        step();
        mac_res_valid = 1'b0;
        #1;
        check("t3_resp_no_ready", 64'(req_ready), 64'd0);
        check("t3_res_id", 64'(res_id), 64'd2);
        check("t3_res_len", 64'(res_len), 64'd2);
        check("t3_res_data", 64'(res_data), 64'hABC);
        step();
        check("t3_resp_held", 64'(dbg_state), 64'd3);
        check("t3_resp_held_ready", 64'(req_ready), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        #1;
        check("t3_idle_no_ready", 64'(req_ready), 64'd0);
        step();
        check("t3_next_owner0", 64'(req_ready), 64'b0001);
        req_last[0] = 1'b1;
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 14'h0);
        mac_res_valid = 1'b1;
        mac_res       = 28'h55;
        step();
        mac_res_valid = 1'b0;
        #1;
        check("t3_res_id0", 64'(res_id), 64'd0);
        check("t3_res_len0", 64'(res_len), 64'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // ---- timeout: requester 1, no MAC result ----
        set_req(1, 1'b1, 1'b1, 14'h0007, 14'h0008);
        #1;
        step();
        check("t4_owner1", 64'(req_ready), 64'b0010);
        step();
        set_req(1, 1'b0, 1'b0, 14'h0, 14'h0);
        for (int k = 0; k < TIMEOUT; k++) begin
            #1;
            check($sformatf("t4_wait_%0d", k), 64'(dbg_state), 64'd2);
            step();
        end
        check("t4_state_resp", 64'(dbg_state), 64'd3);
        check("t4_res_err", 64'(res_err), 64'd1);
        check("t4_res_data", 64'(res_data), 64'd0);
        check("t4_res_id", 64'(res_id), 64'd1);
        check("t4_res_len", 64'(res_len), 64'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // ---- mac_ready gating the last beat, held response, overflow ----
        set_req(3, 1'b1, 1'b0, 14'h0031, 14'h0032);
        #1;
        step();
        check("t5_owner3", 64'(req_ready), 64'b1000);
        step();
        set_req(3, 1'b1, 1'b1, 14'h0033, 14'h0034);
        mac_ready = 1'b0;
        #1;
        check("t5_ready_low", 64'(req_ready), 64'd0);
        check("t5_mac_last_offered", 64'(mac_last), 64'd1);
        step();
        check("t5_still_stream", 64'(dbg_state), 64'd1);
        check("t5_len_unchanged", 64'(res_len), 64'd1);
        mac_ready = 1'b1;
        #1;
        check("t5_ready_high", 64'(req_ready), 64'b1000);
        step();
        set_req(3, 1'b0, 1'b0, 14'h0, 14'h0);
        mac_res_valid = 1'b1;
        mac_ovf       = 1'b1;
        mac_res       = 28'h1234567;
        step();
        // A stray result while in RESP must not disturb the held payload.
        mac_res_valid = 1'b1;
        mac_ovf       = 1'b0;
        mac_res       = 28'hFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_hold_valid_%0d", k), 64'(res_valid), 64'd1);
            check($sformatf("t5_hold_data_%0d", k), 64'(res_data), 64'h1234567);
            check($sformatf("t5_hold_id_%0d", k), 64'(res_id), 64'd3);
            check($sformatf("t5_hold_len_%0d", k), 64'(res_len), 64'd2);
            check($sformatf("t5_hold_err_%0d", k), 64'(res_err), 64'd1);
            step();
        end
        mac_res_valid = 1'b0;
        mac_res       = '0;
        res_ready     = 1'b1;
        step();
        res_ready = 1'b0;

        // ---- reset mid-packet ----
        set_req(0, 1'b1, 1'b1, 14'h0001, 14'h0001);
        #1;
        step();
        step();
        set_req(0, 1'b0, 1'b0, 14'h0, 14'h0);
        mac_res_valid = 1'b1;
        mac_res       = 28'h99;
        step();
        mac_res_valid = 1'b0;
        res_ready     = 1'b1;
        step();
        res_ready = 1'b0;
        set_req(2, 1'b1, 1'b0, 14'h002A, 14'h002B);
        #1;
        step();
        check("t6_owner2", 64'(req_ready), 64'b0100);
        step();
        step();
        check("t6_two_beats", 64'(res_len), 64'd2);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 14'(i + 5), 14'(i + 6));
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        rstn = 1'b1;
        step();
        check("t6_restart_owner0", 64'(req_ready), 64'b0001);
        check("t6_restart_mac_a", 64'(mac_a), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Shares one fixed-point MAC datapath (multiply, accumulate, flush-on-last) between NUM_REQ streaming requesters.
- Round-robin arbitration at packet granularity: a packet is a run of beats ending with last. One packet is in flight at a time.
- Forwards the winner's beats to the MAC, waits for its accumulated result, then returns the result tagged with the owner ID.
- Sits between the requester fabric and the single MAC instance.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8
- A_W, 14, operand a width (int_a+frac_a)
- B_W, 14, operand b width (int_b+frac_b)
- RES_W, 28, MAC result width (out_int+out_frac)
- LEN_W, 16, beat-counter width
- TIMEOUT, 1024, max cycles in WAIT_RES before error, ≥2

Ports:
- clock  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_a  in  NUM_REQ*A_W  flattened operand a; slice i = requester i
- req_b  in  NUM_REQ*B_W  flattened operand b
- req_ready  out  NUM_REQ  per-requester beat accept
- mac_valid  out  1  beat valid to MAC
- mac_last  out  1  last flag to MAC
- mac_a  out  A_W  operand a to MAC
- mac_b  out  B_W  operand b to MAC
- mac_ready  in  1  MAC accepts beat
- mac_res_valid  in  1  MAC result pulse
- mac_res  in  RES_W  MAC accumulated result
- mac_ovf  in  1  MAC overflow/underflow flag, sampled with mac_res_valid
- res_valid  out  1  result to owner valid
- res_ready  in  1  result consumer accept
- res_data  out  RES_W  returned result
- res_id  out  $clog2(NUM_REQ)  owner requester index
- res_len  out  LEN_W  beats accepted in the packet
- res_err  out  1  timeout or MAC overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low, async): state=IDLE, rr pointer=0, owner=0, beat count=0, timeout count=0. All outputs 0.
- States: IDLE, STREAM, WAIT_RES, RESP.
- IDLE:
  - Scan req_valid starting at the rr pointer and wrapping. The first set bit becomes the owner (registered); go to STREAM next cycle.
  - No beat is accepted in IDLE; arbitration costs 1 cycle.
- STREAM:
  - mac_valid=req_valid[owner]; mac_a/mac_b/mac_last = owner slices. These are combinational mux outputs.
  - req_ready[owner]=mac_ready; all other req_ready=0.
  - A beat is accepted when mac_valid&&mac_ready; beat count increments by 1 and saturates at all-ones.
  - Accepted beat with last → WAIT_RES. Other requesters' valid/last are ignored; the grant stays locked.
- WAIT_RES:
  - mac_valid=0, all req_ready=0. The timeout counter increments each cycle.
  - On mac_res_valid: capture mac_res into res_data, set res_err=mac_ovf, go to RESP.
  - If the counter reaches TIMEOUT-1 without mac_res_valid: res_data=0, res_err=1, go to RESP.
  - mac_res_valid outside WAIT_RES is ignored.
- RESP:
  - res_valid=1; res_data/res_id/res_len/res_err are held stable until res_ready.
  - On res_valid&&res_ready: rr pointer=(owner+1) mod NUM_REQ, clear counters, go to IDLE.
  - A just-served requester requesting again gets lowest priority.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Simultaneous events:
  - mac_res_valid on the timeout cycle → the result wins and res_err=mac_ovf.
  - A req_last beat with mac_ready low is not accepted; stay in STREAM.
- Reset mid-packet aborts everything; the MAC is reset by the same rstn.
- Outputs in RESP and res_* are registered; the MAC-side beat path is combinational from the owner register.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, STREAM=1, WAIT_RES=2, RESP=3) and an ID-width function clog2.
- One sub-module: rr_arbiter (combinational priority rotate; inputs req vector and pointer; outputs one-hot grant and index). Reusable elsewhere.

Test Plan:
- Single requester 1, packet of 3 beats, mac_ready=1, MAC returns 0x00_0640 after 2 cycles → req_ready[1] high 3 cycles; res_valid with res_id=1, res_len=3, res_data=0x640, res_err=0.
- All 4 requesters valid continuously with 2-beat packets, res_ready=1 → grant order 0,1,2,3,0; no beats accepted from non-owners.
- Requester 2 mid-packet, requester 0 asserts valid → req_ready[0] stays 0 until requester 2's result handshake completes; next owner is 3 if valid, else 0.
- mac_res_valid never arrives, TIMEOUT=8 → RESP after 8 WAIT_RES cycles; res_err=1, res_data=0.
- mac_ready toggling 1,0,1 on a last beat, and res_ready held low 5 cycles → last accepted only when ready; res_* stable for all 5 cycles; mac_ovf=1 at the result gives res_err=1.
- rstn low during STREAM after 2 beats → all outputs 0 immediately; after release, arbitration restarts from requester 0.
